a2d_spi_resp: RTL and testbench

Synthesizable SPI responder that models the 8-channel 12-bit A2D converter sitting on the far side of the slide-pot A2D SPI link.
- Receives 16-bit command frames that carry a channel number.
- Returns the held conversion value of the channel addressed in the previous frame (pipelined, ADC128S-style).
- Used in FPGA-loopback and full-chip simulation in place of the real converter; channel values come from a parallel input bus.

---
 rtl/a2d_pkg.sv | 25 ++
 rtl/a2d_spi_resp_if.sv | 10 +
 rtl/spi_sync_edge.sv | 23 ++
 rtl/a2d_spi_resp.sv | 119 +++++++++++
 tb/tb_a2d_spi_resp.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/a2d_pkg.sv
// Shared constants, channel map and state type for the slide-pot A2D SPI responder.
package a2d_pkg;

   localparam int NUM_CH  = 8;
   localparam int DATA_W  = 12;
   localparam int FRAME_W = 16;
   localparam int CH_W    = 3;

   // Channel number field inside a received command frame
   localparam int CH_MSB = 13;
   localparam int CH_LSB = 11;

   localparam logic [4:0] GOOD_BITS = 5'd16;
   localparam logic [4:0] MAX_BITS  = 5'd17;

   localparam logic [2:0] CH_LP  = 3'd1;
   localparam logic [2:0] CH_B1  = 3'd0;
   localparam logic [2:0] CH_B2  = 3'd4;
   localparam logic [2:0] CH_B3  = 3'd2;
   localparam logic [2:0] CH_HP  = 3'd3;
   localparam logic [2:0] CH_VOL = 3'd7;

   typedef enum logic [1:0] {WAIT_HI, IDLE, XFER} state_t;

endpackage

// File: rtl/a2d_spi_resp_if.sv
// SPI pin bundle between the initiator and the A2D responder.
interface a2d_spi_resp_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus a third flop for single-clk rise/fall pulses.
module spi_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [2:0] ff;

   // Resets low so a line already high is seen as a fresh rise, never a fall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[1:0], din};
   end

   assign level = ff[1];
   assign rise  = ff[1] & ~ff[2];
   assign fall  = ~ff[1] & ff[2];

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel 12-bit pipelined A2D: each frame returns
// the value of the channel addressed by the previous good frame.
module a2d_spi_resp
   import a2d_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   a2d_spi_resp_if.slave            spi,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [CH_W-1:0]          cur_chnnl,
   output logic                     frame_done,
   output logic                     frame_err,
   output logic [7:0]               frame_cnt
);

   // Only the bits up to the channel field are worth keeping
   localparam int RX_W = CH_MSB + 1;

   logic ss_lvl, ss_rise, ss_fall;
   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic [1:0] mosi_ff;

   state_t state, state_nxt;
   logic load_tx, shift_rx, shift_tx, good, bad;

   logic [FRAME_W-1:0] tx_shft;
   logic [RX_W-1:0]    rx_shft;
   logic [4:0]         bit_cnt;

   spi_sync_edge u_ss_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi.SS_n),
      .level (ss_lvl),
      .rise  (ss_rise),
      .fall  (ss_fall)
   );

   spi_sync_edge u_sclk_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi.SCLK),
      .level (sclk_level_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_ff <= '0;
      else        mosi_ff <= {mosi_ff[0], spi.MOSI};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_HI;
      else        state <= state_nxt;
   end

   // SS_n edges take priority: any SCLK edge in the same clk is dropped
   always_comb begin
      state_nxt = state;
      load_tx   = 1'b0;
      shift_rx  = 1'b0;
      shift_tx  = 1'b0;
      good      = 1'b0;
      bad       = 1'b0;
      case (state)
         WAIT_HI: if (ss_lvl) state_nxt = IDLE;
         IDLE: begin
            if (ss_fall) begin
               load_tx   = 1'b1;
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (ss_rise) begin
               state_nxt = IDLE;
               good      = (bit_cnt == GOOD_BITS);
               bad       = (bit_cnt != GOOD_BITS);
            end else if (!ss_fall) begin
               shift_rx = sclk_rise;
               shift_tx = sclk_fall;
            end
         end
         default: state_nxt = WAIT_HI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shft    <= '0;
         rx_shft    <= '0;
         bit_cnt    <= '0;
         cur_chnnl  <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= good;
         frame_err  <= bad;
         if (load_tx) begin
            tx_shft <= {{(FRAME_W-DATA_W){1'b0}}, ch_data[int'(cur_chnnl)*DATA_W +: DATA_W]};
            bit_cnt <= '0;
         end else if (shift_tx) begin
            tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
         end
         if (shift_rx) begin
            rx_shft <= {rx_shft[RX_W-2:0], mosi_ff[1]};
            if (bit_cnt != MAX_BITS) bit_cnt <= bit_cnt + 5'd1;
         end
         if (good) begin
            cur_chnnl <= rx_shft[CH_MSB:CH_LSB];
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   assign spi.MISO = (state == XFER) ? tx_shft[FRAME_W-1] : 1'b0;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Randomized self-checking bench for a2d_spi_resp against a channel/frame-count model.
module tb_a2d_spi_resp;
   import a2d_pkg::*;

   localparam int HALF = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   a2d_spi_resp_if spi ();

   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [2:0] cur_chnnl;
   logic       frame_done, frame_err;
   logic [7:0] frame_cnt;

   a2d_spi_resp dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi        (spi.slave),
      .ch_data    (ch_data),
      .cur_chnnl  (cur_chnnl),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt)
   );

   int checks = 0;
   int passed = 0;
   int done_seen = 0;
   int err_seen = 0;

   // Reference model: channel values, latched channel and good-frame count
   logic [11:0] ch_vals [8];
   int model_cur = 0;
   int model_cnt = 0;

   always @(negedge clk) begin
      if (frame_done === 1'b1) done_seen++;
      if (frame_err === 1'b1) err_seen++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ch(input int k, input logic [11:0] v);
      ch_vals[k] = v;
      ch_data[k*12 +: 12] = v;
   endtask

   function automatic logic [15:0] mk_cmd(input int ch);
      logic [15:0] m;
      m = 16'($urandom);
      m[13:11] = 3'(ch);
      return m;
   endfunction

   function automatic logic [15:0] expected_word();
      return {4'h0, ch_vals[model_cur]};
   endfunction

   task automatic model_good(input logic [15:0] cmd);
      model_cur = int'(cmd[13:11]);
      model_cnt = (model_cnt + 1) % 256;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      spi.SS_n = 1'b1;
      spi.SCLK = 1'b0;
      spi.MOSI = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(6);
      model_cur = 0;
      model_cnt = 0;
   endtask

   task automatic run_frame(input logic [15:0] mosi_w, input int nrises, input int chg_at,
                            input logic [11:0] chg_val, output logic [15:0] miso_w,
                            output int d_done, output int d_err);
      int d0, e0;
      d0 = done_seen;
      e0 = err_seen;
      miso_w = '0;
      @(negedge clk);
      spi.SS_n = 1'b0;
      wait_clk(HALF + 2);
      for (int i = 0; i < nrises; i++) begin
         if (i == chg_at) set_ch(model_cur, chg_val);
         spi.MOSI = (i < 16) ? mosi_w[15-i] : 1'b0;
         wait_clk(HALF);
         if (i < 16) miso_w[15-i] = spi.MISO;
         spi.SCLK = 1'b1;
         wait_clk(HALF);
         spi.SCLK = 1'b0;
      end
      wait_clk(HALF);
      spi.SS_n = 1'b1;
      wait_clk(8);
      d_done = done_seen - d0;
      d_err = err_seen - e0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      spi.SS_n = 1'b1;
      spi.SCLK = 1'b0;
      spi.MOSI = 1'b0;
      for (int k = 0; k < 8; k++) set_ch(k, 12'($urandom));
      wait_clk(4);
      checks++;
      if ({spi.MISO, cur_chnnl, frame_done, frame_err, frame_cnt} !== 14'h0)
         $display("[TB] FAIL reset_outputs: got miso=%b cur=%0d done=%b err=%b cnt=%0d, expected all zero",
                  spi.MISO, cur_chnnl, frame_done, frame_err, frame_cnt);
      else passed++;
      rst_n = 1'b1;
      wait_clk(6);
      model_cur = 0;
      model_cnt = 0;
   endtask

   task automatic test_first_frames();
      logic [15:0] miso_w, exp;
      int dd, de;
      set_ch(0, 12'hABC);
      set_ch(1, 12'h123);
      do_reset();
      exp = expected_word();
      run_frame(16'h0800, 16, -1, '0, miso_w, dd, de);
      model_good(16'h0800);
      checks++;
      if (miso_w !== exp) $display("[TB] FAIL first_miso: got %h expected %h", miso_w, exp);
      else passed++;
      checks++;
      if (cur_chnnl !== 3'(model_cur)) $display("[TB] FAIL first_cur: got %0d expected %0d", cur_chnnl, model_cur);
      else passed++;
      checks++;
      if (dd !== 1 || de !== 0) $display("[TB] FAIL first_pulses: got done=%0d err=%0d expected 1/0", dd, de);
      else passed++;
      checks++;
      if (frame_cnt !== 8'(model_cnt)) $display("[TB] FAIL first_cnt: got %0d expected %0d", frame_cnt, model_cnt);
      else passed++;
      exp = expected_word();
      run_frame(16'h3800, 16, -1, '0, miso_w, dd, de);
      model_good(16'h3800);
      checks++;
      if (miso_w !== exp) $display("[TB] FAIL second_miso: got %h expected %h", miso_w, exp);
      else passed++;
      checks++;
      if (cur_chnnl !== 3'(model_cur)) $display("[TB] FAIL second_cur: got %0d expected %0d", cur_chnnl, model_cur);
      else passed++;
   endtask

   task automatic test_slide_sequence();
      logic [2:0] slide [6];
      logic [15:0] miso_w, exp, cmd;
      int dd, de;
      slide = '{CH_LP, CH_B1, CH_B2, CH_B3, CH_HP, CH_VOL};
      for (int k = 0; k < 6; k++) set_ch(int'(slide[k]), 12'h111 * 12'(k + 1));
      set_ch(5, 12'h777);
      set_ch(6, 12'($urandom));
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cmd = mk_cmd(int'(slide[k]));
         exp = expected_word();
         run_frame(cmd, 16, -1, '0, miso_w, dd, de);
         model_good(cmd);
         checks++;
         if (miso_w !== exp || dd !== 1)
            $display("[TB] FAIL slide_frame%0d: got %h done=%0d expected %h done=1", k, miso_w, dd, exp);
         else passed++;
      end
      checks++;
      if (frame_cnt !== 8'd6 || cur_chnnl !== CH_VOL)
         $display("[TB] FAIL slide_end: got cnt=%0d cur=%0d expected cnt=6 cur=%0d", frame_cnt, cur_chnnl, CH_VOL);
      else passed++;
   endtask

   task automatic test_abort();
      logic [15:0] miso_w, exp, cmd;
      int dd, de;
      cmd = mk_cmd((model_cur + 3) % 8);
      exp = expected_word();
      run_frame(cmd, 9, -1, '0, miso_w, dd, de);
      checks++;
      if (dd !== 0 || de !== 1) $display("[TB] FAIL abort_pulses: got done=%0d err=%0d expected 0/1", dd, de);
      else passed++;
      checks++;
      if (cur_chnnl !== 3'(model_cur) || frame_cnt !== 8'(model_cnt))
         $display("[TB] FAIL abort_state: got cur=%0d cnt=%0d expected cur=%0d cnt=%0d",
                  cur_chnnl, frame_cnt, model_cur, model_cnt);
      else passed++;
      checks++;
      if (miso_w[15:7] !== exp[15:7] || spi.MISO !== 1'b0)
         $display("[TB] FAIL abort_miso: got bits %h line=%b expected bits %h line=0", miso_w[15:7], spi.MISO, exp[15:7]);
      else passed++;
      cmd = mk_cmd($urandom_range(0, 7));
      exp = expected_word();
      run_frame(cmd, 16, -1, '0, miso_w, dd, de);
      model_good(cmd);
      checks++;
      if (miso_w !== exp || cur_chnnl !== 3'(model_cur) || dd !== 1)
         $display("[TB] FAIL after_abort: got %h cur=%0d done=%0d expected %h cur=%0d done=1",
                  miso_w, cur_chnnl, dd, exp, model_cur);
      else passed++;
   endtask

   task automatic test_overlength();
      logic [15:0] miso_w, exp, cmd;
      int dd, de;
      cmd = mk_cmd((model_cur + 5) % 8);
      exp = expected_word();
      run_frame(cmd, 17, -1, '0, miso_w, dd, de);
      checks++;
      if (dd !== 0 || de !== 1) $display("[TB] FAIL overlen_pulses: got done=%0d err=%0d expected 0/1", dd, de);
      else passed++;
      checks++;
      if (cur_chnnl !== 3'(model_cur) || frame_cnt !== 8'(model_cnt))
         $display("[TB] FAIL overlen_state: got cur=%0d cnt=%0d expected cur=%0d cnt=%0d",
                  cur_chnnl, frame_cnt, model_cur, model_cnt);
      else passed++;
      checks++;
      if (miso_w !== exp) $display("[TB] FAIL overlen_miso: got %h expected %h", miso_w, exp);
      else passed++;
   endtask

   task automatic test_midframe_change();
      logic [15:0] miso_w, cmd;
      int dd, de;
      set_ch(model_cur, 12'h5A5);
      cmd = mk_cmd($urandom_range(0, 7));
      run_frame(cmd, 16, 4, 12'hFFF, miso_w, dd, de);
      model_good(cmd);
      checks++;
      if (miso_w !== 16'h05A5) $display("[TB] FAIL midframe_snapshot: got %h expected 05a5", miso_w);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      logic [15:0] miso_w, exp, cmd;
      int dd, de, d0, e0, noisy;
      set_ch(0, 12'h0F0);
      set_ch(5, 12'h50A);
      cmd = mk_cmd(5);
      run_frame(cmd, 16, -1, '0, miso_w, dd, de);
      model_good(cmd);
      @(negedge clk);
      spi.SS_n = 1'b0;
      wait_clk(HALF + 2);
      for (int i = 0; i < 3; i++) begin
         spi.SCLK = 1'b1;
         wait_clk(HALF);
         spi.SCLK = 1'b0;
         wait_clk(HALF);
      end
      rst_n = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      model_cur = 0;
      model_cnt = 0;
      d0 = done_seen;
      e0 = err_seen;
      noisy = 0;
      for (int i = 0; i < 4; i++) begin
         spi.MOSI = 1'($urandom);
         wait_clk(HALF);
         if (spi.MISO !== 1'b0) noisy++;
         spi.SCLK = 1'b1;
         wait_clk(HALF);
         if (spi.MISO !== 1'b0) noisy++;
         spi.SCLK = 1'b0;
      end
      wait_clk(HALF);
      spi.SS_n = 1'b1;
      wait_clk(8);
      checks++;
      if (noisy !== 0) $display("[TB] FAIL rst_mid_miso: got %0d active samples expected 0", noisy);
      else passed++;
      checks++;
      if (done_seen - d0 !== 0 || err_seen - e0 !== 0)
         $display("[TB] FAIL rst_mid_pulses: got done=%0d err=%0d expected 0/0", done_seen - d0, err_seen - e0);
      else passed++;
      checks++;
      if (cur_chnnl !== 3'd0 || frame_cnt !== 8'd0)
         $display("[TB] FAIL rst_mid_state: got cur=%0d cnt=%0d expected 0/0", cur_chnnl, frame_cnt);
      else passed++;
      cmd = mk_cmd($urandom_range(0, 7));
      exp = expected_word();
      run_frame(cmd, 16, -1, '0, miso_w, dd, de);
      model_good(cmd);
      checks++;
      if (miso_w !== exp) $display("[TB] FAIL rst_mid_next: got %h expected %h", miso_w, exp);
      else passed++;
   endtask

   task automatic test_back_to_back_wrap();
      logic [15:0] miso_w, exp, cmd;
      int dd, de, bad;
      for (int k = 0; k < 8; k++) set_ch(k, 12'($urandom));
      do_reset();
      bad = 0;
      for (int n = 0; n < 255; n++) begin
         cmd = mk_cmd($urandom_range(0, 7));
         exp = expected_word();
         run_frame(cmd, 16, -1, '0, miso_w, dd, de);
         model_good(cmd);
         if (miso_w !== exp || dd !== 1 || cur_chnnl !== 3'(model_cur)) bad++;
      end
      checks++;
      if (bad !== 0) $display("[TB] FAIL b2b_frames: got %0d wrong frames expected 0", bad);
      else passed++;
      checks++;
      if (frame_cnt !== 8'(model_cnt)) $display("[TB] FAIL cnt_255: got %0d expected %0d", frame_cnt, model_cnt);
      else passed++;
      cmd = mk_cmd($urandom_range(0, 7));
      run_frame(cmd, 16, -1, '0, miso_w, dd, de);
      model_good(cmd);
      checks++;
      if (frame_cnt !== 8'(model_cnt)) $display("[TB] FAIL cnt_wrap: got %0d expected %0d", frame_cnt, model_cnt);
      else passed++;
   endtask

   initial begin
      spi.SS_n = 1'b1;
      spi.SCLK = 1'b0;
      spi.MOSI = 1'b0;
      ch_data = '0;
      test_reset();
      test_first_frames();
      test_slide_sequence();
      test_abort();
      test_overlength();
      test_midframe_change();
      test_reset_midframe();
      test_back_to_back_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
